// File: rtl/hfg_prefeature_gen_17x17_if.sv
// Descriptor, integral-RAM read port and result bundle for the Haar pre-feature generator.
// The slave modport is the generator; the master side drives descriptors and returns RAM data.
interface hfg_prefeature_gen_17x17_if #(
  parameter int unsigned IDATA_W = 17,
  parameter int unsigned OUT_W   = 21
);
  logic               iStart;
  logic [1:0]         iNum_Rect;
  logic [22:0]        iRect0;
  logic [22:0]        iRect1;
  logic [22:0]        iRect2;
  logic               iBank;
  logic               oRd_En;
  logic [9:0]         oRd_Addr;
  logic [IDATA_W-1:0] iRd_Data;
  logic               oBusy;
  logic               oValid;
  logic [OUT_W-1:0]   oPre_Feature;
  logic               oErr;

  modport master (
    output iStart, iNum_Rect, iRect0, iRect1, iRect2, iBank, iRd_Data,
    input  oRd_En, oRd_Addr, oBusy, oValid, oPre_Feature, oErr
  );

  modport slave (
    input  iStart, iNum_Rect, iRect0, iRect1, iRect2, iBank, iRd_Data,
    output oRd_En, oRd_Addr, oBusy, oValid, oPre_Feature, oErr
  );
endinterface

// File: rtl/hfg_prefeature_gen_17x17.sv
// Weighted 2/3-rectangle Haar pre-feature over an 18x18 integral-image window.
// Corner reads go out one per cycle; a tag pipeline lines each returned word up with its sign and weight.
module hfg_prefeature_gen_17x17 #(
  parameter int unsigned IDATA_W = 17,
  parameter int unsigned OUT_W   = 21
) (
  input  logic                       iClk,
  input  logic                       iReset,
  hfg_prefeature_gen_17x17_if.slave  bus
);

  localparam int unsigned ACC_W  = OUT_W + 1;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LIN_W  = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DIM    = 18;

  typedef struct packed {
    logic [4:0]        x;
    logic [4:0]        y;
    logic [4:0]        w;
    logic [4:0]        h;
    logic signed [2:0] wt;
  } rect_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  rect_t                    rect_q [3];
  rect_t                    rect_d [3];
  logic [1:0]               nrect_q, nrect_d;
  logic                     bank_q, bank_d;
  logic                     err_q, err_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     tag0_neg_q, tag0_neg_d;
  logic signed [2:0]        tag0_wt_q, tag0_wt_d;
  logic                     tag1_vld_q, tag1_neg_q;
  logic signed [2:0]        tag1_wt_q;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic [OUT_W-1:0]         pre_q, pre_d;
  logic                     oerr_q, oerr_d;

  logic [IDATA_W-1:0]       rd_data;
  logic                     desc_bad;
  logic [IDX_W-1:0]         n_reads;
  logic signed [ACC_W-1:0]  data_s, wt_s, term;
  logic                     issue;
  logic [IDX_W-1:0]         issue_idx;
  rect_t                    cur;
  logic [4:0]               row, col;

  function automatic logic rect_bad(input rect_t r);
    return (r.w == 5'd0) || (r.h == 5'd0) ||
           ((6'(r.x) + 6'(r.w)) > 6'd17) || ((6'(r.y) + 6'(r.h)) > 6'd17);
  endfunction

  assign rd_data = bus.iRd_Data;

  // Descriptor check and signed weighted term of the returning word
  always_comb begin
    desc_bad = !((nrect_q == 2'd2) || (nrect_q == 2'd3)) ||
               rect_bad(rect_q[0]) || rect_bad(rect_q[1]) ||
               ((nrect_q == 2'd3) && rect_bad(rect_q[2]));
    n_reads  = (nrect_q == 2'd3) ? IDX_W'(12) : IDX_W'(8);
    data_s   = $signed(ACC_W'(rd_data));
    wt_s     = ACC_W'(tag1_wt_q);
    term     = data_s * wt_s;
  end

  always_comb begin
    state_d    = state_q;
    rect_d     = rect_q;
    nrect_d    = nrect_q;
    bank_d     = bank_q;
    err_d      = err_q;
    idx_d      = idx_q;
    acc_d      = tag1_vld_q ? (tag1_neg_q ? acc_q - term : acc_q + term) : acc_q;
    tag0_neg_d = tag0_neg_q;
    tag0_wt_d  = tag0_wt_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    valid_d    = 1'b0;
    oerr_d     = 1'b0;
    pre_d      = pre_q;
    issue      = 1'b0;
    issue_idx  = idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          rect_d[0] = rect_t'(bus.iRect0);
          rect_d[1] = rect_t'(bus.iRect1);
          rect_d[2] = rect_t'(bus.iRect2);
          nrect_d   = bus.iNum_Rect;
          bank_d    = bus.iBank;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        err_d = desc_bad;
        acc_d = '0;
        // A rejected descriptor still spends one DRAIN cycle so both paths share the DONE timing
        if (desc_bad) begin
          state_d = S_DRAIN;
        end else begin
          state_d   = S_READ;
          issue     = 1'b1;
          issue_idx = '0;
        end
      end
      S_READ: begin
        if (idx_q == n_reads) state_d = S_DRAIN;
        else                  issue   = 1'b1;
      end
      S_DRAIN: begin
        state_d = S_DONE;
        valid_d = 1'b1;
        oerr_d  = err_q;
        pre_d   = err_q ? '0 : OUT_W'(acc_d);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Corner order per rectangle: A(y,x) B(y,x+w) C(y+h,x) D(y+h,x+w)
    cur = rect_q[issue_idx[3:2]];
    row = issue_idx[1] ? (cur.y + cur.h) : cur.y;
    col = issue_idx[0] ? (cur.x + cur.w) : cur.x;
    if (issue) begin
      rd_en_d    = 1'b1;
      rd_addr_d  = {bank_q, LIN_W'(row) * LIN_W'(DIM) + LIN_W'(col)};
      tag0_neg_d = issue_idx[0] ^ issue_idx[1];
      tag0_wt_d  = cur.wt;
      idx_d      = issue_idx + IDX_W'(1);
    end

    busy_d = (state_d == S_CHECK) || (state_d == S_READ) || (state_d == S_DRAIN);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      rect_q     <= '{default: '0};
      nrect_q    <= '0;
      bank_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      acc_q      <= '0;
      tag0_neg_q <= 1'b0;
      tag0_wt_q  <= '0;
      tag1_vld_q <= 1'b0;
      tag1_neg_q <= 1'b0;
      tag1_wt_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      pre_q      <= '0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rect_q     <= rect_d;
      nrect_q    <= nrect_d;
      bank_q     <= bank_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      tag0_neg_q <= tag0_neg_d;
      tag0_wt_q  <= tag0_wt_d;
      tag1_vld_q <= rd_en_q;
      tag1_neg_q <= tag0_neg_q;
      tag1_wt_q  <= tag0_wt_q;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      pre_q      <= pre_d;
      oerr_q     <= oerr_d;
    end
  end

  assign bus.oRd_En       = rd_en_q;
  assign bus.oRd_Addr     = rd_addr_q;
  assign bus.oBusy        = busy_q;
  assign bus.oValid       = valid_q;
  assign bus.oPre_Feature = pre_q;
  assign bus.oErr         = oerr_q;

endmodule
